ahb_decoder_ctrl: RTL

Address decoder and data-phase controller that sits directly upstream of the 4-slave AHB read-data/response multiplexor.
- In the address phase, decodes haddr into one-hot slave selects.
- Registers the data-phase select `sel` that drives the multiplexor.
- Forms the final hready/hresp seen by the master and all slaves.
- Contains a built-in default slave that returns a two-cycle ERROR response for unmapped addresses.

---
 rtl/ahb_decoder_ctrl.sv | 126 ++++++++++++
 1 files changed

// File: rtl/ahb_decoder_ctrl.sv
// AHB address decoder and data-phase controller for a 4-slave read-data/response mux,
// with a built-in default slave that answers unmapped transfers with a two-cycle ERROR.
//
// state  | meaning
// NOXFER | no transfer in data phase (IDLE/BUSY or after reset); zero-wait OKAY
// SLAVE  | mapped slave owns the data phase; hready/hresp pass through from the mux
// ERR1   | default slave, first ERROR cycle (hready low)
// ERR2   | default slave, second ERROR cycle (hready high)
module ahb_decoder_ctrl #(
    parameter logic [3:0] S1_BASE = 4'h0,
    parameter logic [3:0] S2_BASE = 4'h1,
    parameter logic [3:0] S3_BASE = 4'h2,
    parameter logic [3:0] S4_BASE = 4'h3
) (
    input  logic        hclk,
    input  logic        hreset,
    input  logic [31:0] haddr,
    input  logic [1:0]  htrans,
    input  logic        mux_hreadyout,
    input  logic        mux_hresp,
    output logic        hsel_1,
    output logic        hsel_2,
    output logic        hsel_3,
    output logic        hsel_4,
    output logic [1:0]  sel,
    output logic        hready,
    output logic        hresp
);

    typedef enum logic [1:0] {
        NOXFER = 2'b00,
        SLAVE  = 2'b01,
        ERR1   = 2'b10,
        ERR2   = 2'b11
    } state_t;

    state_t     state;
    state_t     state_nxt;
    logic [1:0] sel_nxt;
    logic       valid;
    logic       match_1;
    logic       match_2;
    logic       match_3;
    logic       match_4;
    logic       unmapped;
    logic       unused_bits;

    assign unused_bits = ^{haddr[27:0], htrans[0]};

    // Priority chain: lowest-numbered slave wins when bases overlap.
    assign valid   = htrans[1];
    assign match_1 = (haddr[31:28] == S1_BASE);
    assign match_2 = (haddr[31:28] == S2_BASE);
    assign match_3 = (haddr[31:28] == S3_BASE);
    assign match_4 = (haddr[31:28] == S4_BASE);

    assign hsel_1   = valid && match_1;
    assign hsel_2   = valid && match_2 && !match_1;
    assign hsel_3   = valid && match_3 && !match_1 && !match_2;
    assign hsel_4   = valid && match_4 && !match_1 && !match_2 && !match_3;
    assign unmapped = valid && !(match_1 || match_2 || match_3 || match_4);

    always_comb begin
        state_nxt = state;
        sel_nxt   = sel;
        hready    = 1'b1;
        hresp     = 1'b0;

        case (state)
            NOXFER: begin
                hready = 1'b1;
                hresp  = 1'b0;
            end
            SLAVE: begin
                hready = mux_hreadyout;
                hresp  = mux_hresp;
            end
            ERR1: begin
                hready = 1'b0;
                hresp  = 1'b1;
            end
            ERR2: begin
                hready = 1'b1;
                hresp  = 1'b1;
            end
            default: begin
                hready = 1'b1;
                hresp  = 1'b0;
            end
        endcase

        // sel only moves on a mapped transfer; unmapped/idle keep the last slave selected.
        if (state == ERR1) begin
            state_nxt = ERR2;
        end else if (hready) begin
            if (hsel_1) begin
                state_nxt = SLAVE;
                sel_nxt   = 2'b00;
            end else if (hsel_2) begin
                state_nxt = SLAVE;
                sel_nxt   = 2'b01;
            end else if (hsel_3) begin
                state_nxt = SLAVE;
                sel_nxt   = 2'b10;
            end else if (hsel_4) begin
                state_nxt = SLAVE;
                sel_nxt   = 2'b11;
            end else if (unmapped) begin
                state_nxt = ERR1;
            end else begin
                state_nxt = NOXFER;
            end
        end
    end

    always_ff @(posedge hclk) begin
        if (hreset) begin
            state <= NOXFER;
            sel   <= 2'b00;
        end else begin
            state <= state_nxt;
            sel   <= sel_nxt;
        end
    end

endmodule
